board_renderer: RTL and testbench

- Reads the GoBang board-state RAM that the datapath writes, and converts each cell into pixel writes for the 160x120 VGA adapter (plot/x/y/colour interface).
- Writer side: datapath stores stones. Reader side: this block scans every cell on request and repaints it, including a cursor highlight.
- Sits between the board RAM read port and the VGA adapter; triggered by a start pulse from the control FSM after each put, move or reset.

---
 rtl/board_renderer_if.sv | 30 +++
 rtl/board_renderer.sv | 166 ++++++++++++++++
 tb/tb_board_renderer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/board_renderer_if.sv
// Renderer handshake bundle: start/cursor request, board RAM read port,
// and the pixel-write side toward the VGA adapter.
interface board_renderer_if #(
   parameter int BOARD_N = 8
);
   localparam int CW = $clog2(BOARD_N);
   localparam int AW = $clog2(BOARD_N * BOARD_N);

   logic          start;
   logic [CW-1:0] cursor_row;
   logic [CW-1:0] cursor_col;
   logic [AW-1:0] rd_addr;
   logic [1:0]    rd_data;
   logic [7:0]    x;
   logic [6:0]    y;
   logic [2:0]    colour;
   logic          plot;
   logic          busy;
   logic          done;

   modport master (
      output start, cursor_row, cursor_col, rd_data,
      input  rd_addr, x, y, colour, plot, busy, done
   );

   modport slave (
      input  start, cursor_row, cursor_col, rd_data,
      output rd_addr, x, y, colour, plot, busy, done
   );
endinterface

// File: rtl/board_renderer.sv
// Scans the GoBang board RAM and repaints every cell as a CELL_PX square,
// with a border highlighting the cursor cell latched at start.
module board_renderer #(
   parameter int       BOARD_N    = 8,
   parameter int       CELL_PX    = 8,
   parameter int       ORIGIN_X   = 0,
   parameter int       ORIGIN_Y   = 0,
   parameter bit [2:0] COL_EMPTY  = 3'b110,
   parameter bit [2:0] COL_P0     = 3'b000,
   parameter bit [2:0] COL_P1     = 3'b111,
   parameter bit [2:0] COL_GRID   = 3'b001,
   parameter bit [2:0] COL_CURSOR = 3'b100
) (
   input logic              clock,
   input logic              reset,
   board_renderer_if.slave  bus
);
   localparam int CW = $clog2(BOARD_N);
   localparam int AW = $clog2(BOARD_N * BOARD_N);
   localparam int PW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_WAIT, S_DRAW, S_DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] row, col;
   logic [CW-1:0] cur_row, cur_col;
   logic [PW-1:0] px, py;
   logic [1:0]    cell_state;

   logic          last_px, last_pix, last_col, last_cell, on_cursor;
   logic [PW-1:0] npx, npy;
   logic [CW-1:0] nrow, ncol;

   assign last_px   = (px == PW'(CELL_PX - 1));
   assign last_pix  = last_px && (py == PW'(CELL_PX - 1));
   assign last_col  = (col == CW'(BOARD_N - 1));
   assign last_cell = last_col && (row == CW'(BOARD_N - 1));
   assign on_cursor = (row == cur_row) && (col == cur_col);

   always_comb begin
      npx  = last_px ? '0 : px + PW'(1);
      npy  = last_px ? py + PW'(1) : py;
      ncol = last_col ? '0 : col + CW'(1);
      nrow = last_col ? row + CW'(1) : row;
   end

   function automatic logic [AW-1:0] cell_addr(
      input logic [CW-1:0] r,
      input logic [CW-1:0] c
   );
      return AW'(r) * AW'(BOARD_N) + AW'(c);
   endfunction

   // Coordinates are formed at 10 bits, then truncated to the port width.
   function automatic logic [7:0] pix_x(
      input logic [CW-1:0] c,
      input logic [PW-1:0] p
   );
      logic [9:0] v;
      v = 10'(ORIGIN_X) + 10'(c) * 10'(CELL_PX) + 10'(p);
      return v[7:0];
   endfunction

   function automatic logic [6:0] pix_y(
      input logic [CW-1:0] r,
      input logic [PW-1:0] p
   );
      logic [9:0] v;
      v = 10'(ORIGIN_Y) + 10'(r) * 10'(CELL_PX) + 10'(p);
      return v[6:0];
   endfunction

   function automatic logic [2:0] pix_colour(
      input logic [PW-1:0] ppx,
      input logic [PW-1:0] ppy,
      input logic [1:0]    st,
      input logic          cur
   );
      logic edge_px;
      logic [2:0] c;
      edge_px = (ppx == '0) || (ppy == '0);
      c = COL_EMPTY;
      unique case (1'b1)
         edge_px && cur:          c = COL_CURSOR;
         edge_px && !cur:         c = COL_GRID;
         !edge_px && st == 2'b01: c = COL_P0;
         !edge_px && st == 2'b10: c = COL_P1;
         default:                 c = COL_EMPTY;
      endcase
      return c;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         row         <= '0;
         col         <= '0;
         cur_row     <= '0;
         cur_col     <= '0;
         px          <= '0;
         py          <= '0;
         cell_state  <= '0;
         bus.rd_addr <= '0;
         bus.x       <= '0;
         bus.y       <= '0;
         bus.colour  <= '0;
         bus.plot    <= 1'b0;
         bus.busy    <= 1'b0;
         bus.done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  cur_row     <= bus.cursor_row;
                  cur_col     <= bus.cursor_col;
                  row         <= '0;
                  col         <= '0;
                  bus.rd_addr <= '0;
                  bus.busy    <= 1'b1;
                  state       <= S_READ;
               end
            end
            S_READ: state <= S_WAIT;
            S_WAIT: begin
               // First pixel is always a border, so cell_state is not yet needed.
               cell_state <= bus.rd_data;
               px         <= '0;
               py         <= '0;
               bus.plot   <= 1'b1;
               bus.x      <= pix_x(col, '0);
               bus.y      <= pix_y(row, '0);
               bus.colour <= on_cursor ? COL_CURSOR : COL_GRID;
               state      <= S_DRAW;
            end
            S_DRAW: begin
               if (last_pix) begin
                  bus.plot <= 1'b0;
                  row      <= nrow;
                  col      <= ncol;
                  if (last_cell) begin
                     bus.done <= 1'b1;
                     state    <= S_DONE;
                  end else begin
                     bus.rd_addr <= cell_addr(nrow, ncol);
                     state       <= S_READ;
                  end
               end else begin
                  px         <= npx;
                  py         <= npy;
                  bus.x      <= pix_x(col, npx);
                  bus.y      <= pix_y(row, npy);
                  bus.colour <= pix_colour(npx, npy, cell_state, on_cursor);
               end
            end
            S_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: full-frame cycle model, RAM model,
// cursor latching, ignored restarts and asynchronous reset.
module tb_board_renderer;
   localparam int FRAME = 4224;
   localparam int CELLC = 66;

   logic clk;
   logic rst;

   board_renderer_if #(.BOARD_N(8)) bus ();

   board_renderer dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] mem [64];
   always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

   logic [2:0] scr [64][64];

   int vectors;
   int miscompares;
   int st_plots, st_done_k, st_done_cnt;
   int st_pix_err, st_addr_err, st_busy_err, st_idle_err;
   int fb_k, fb_x, fb_y, fb_c, fb_ec;

   function automatic logic [2:0] exp_colour(
      input int r, input int c, input int px, input int py,
      input int cr, input int cc, input logic [1:0] v
   );
      if (px == 0 || py == 0)
         return (r == cr && c == cc) ? 3'b100 : 3'b001;
      if (v == 2'b01) return 3'b000;
      if (v == 2'b10) return 3'b111;
      return 3'b110;
   endfunction

   task automatic run_frame(input int cr, input int cc, input int poke_k);
      int i, off, p, r, c, ex, ey;
      logic [2:0] ec;
      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++) scr[a][b] = 3'b010;
      st_plots = 0; st_done_k = 0; st_done_cnt = 0;
      st_pix_err = 0; st_addr_err = 0; st_busy_err = 0; st_idle_err = 0;
      fb_k = 0; fb_x = 0; fb_y = 0; fb_c = 0; fb_ec = 0;
      @(negedge clk);
      bus.cursor_row = 3'(cr);
      bus.cursor_col = 3'(cc);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 1; k <= FRAME + 8; k++) begin
         if (k == poke_k) begin
            bus.start = 1'b1;
            bus.cursor_row = 3'd3;
            bus.cursor_col = 3'd4;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.plot === 1'b1) begin
            st_plots++;
            if (bus.x < 64 && bus.y < 64) scr[bus.x][bus.y] = bus.colour;
         end
         if (bus.done === 1'b1) begin
            st_done_cnt++;
            if (st_done_k == 0) st_done_k = k;
         end
         if (k <= FRAME) begin
            i = (k - 1) / CELLC;
            off = (k - 1) % CELLC;
            r = i / 8;
            c = i % 8;
            if (bus.busy !== 1'b1) st_busy_err++;
            if (off == 0 && bus.rd_addr !== 6'(i)) st_addr_err++;
            if (off < 2) begin
               if (bus.plot !== 1'b0) st_pix_err++;
            end else begin
               p = off - 2;
               ex = c * 8 + p % 8;
               ey = r * 8 + p / 8;
               ec = exp_colour(r, c, p % 8, p / 8, cr, cc, mem[i]);
               if (bus.plot !== 1'b1 || bus.x !== 8'(ex) ||
                   bus.y !== 7'(ey) || bus.colour !== ec) begin
                  if (st_pix_err == 0) begin
                     fb_k = k; fb_x = ex; fb_y = ey;
                     fb_c = int'(bus.colour); fb_ec = int'(ec);
                  end
                  st_pix_err++;
               end
            end
         end else if (k == FRAME + 1) begin
            if (bus.busy !== 1'b1 || bus.plot !== 1'b0) st_busy_err++;
         end else begin
            if (bus.busy !== 1'b0 || bus.plot !== 1'b0 ||
                bus.done !== 1'b0) st_idle_err++;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.cursor_row = '0;
      bus.cursor_col = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (bus.plot !== 1'b0) begin
         miscompares++; $display("FAIL reset_plot got %b want 0", bus.plot);
      end
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
      vectors++;
      if (bus.done !== 1'b0) begin
         miscompares++; $display("FAIL reset_done got %b want 0", bus.done);
      end
      vectors++;
      if (bus.rd_addr !== 6'd0) begin
         miscompares++; $display("FAIL reset_rd_addr got %0d want 0", bus.rd_addr);
      end
      vectors++;
      if (bus.x !== 8'd0 || bus.y !== 7'd0 || bus.colour !== 3'd0) begin
         miscompares++;
         $display("FAIL reset_xyc got %0d,%0d,%b want 0,0,000", bus.x, bus.y, bus.colour);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      vectors++;
      if (bus.busy !== 1'b0) begin
         miscompares++; $display("FAIL idle_no_start got busy %b want 0", bus.busy);
      end
   endtask

   task automatic test_empty_board;
      for (int a = 0; a < 64; a++) mem[a] = 2'b00;
      run_frame(0, 0, 0);
      vectors++;
      if (st_plots != 4096) begin
         miscompares++; $display("FAIL empty_plots got %0d want 4096", st_plots);
      end
      vectors++;
      if (st_done_k != FRAME + 1 || st_done_cnt != 1) begin
         miscompares++;
         $display("FAIL empty_done got cycle %0d count %0d want cycle 4225 count 1",
                  st_done_k, st_done_cnt);
      end
      vectors++;
      if (st_pix_err != 0) begin
         miscompares++;
         $display("FAIL empty_pixels got %0d bad, first k=%0d (%0d,%0d) colour %b want %b",
                  st_pix_err, fb_k, fb_x, fb_y, fb_c[2:0], fb_ec[2:0]);
      end
      vectors++;
      if (st_addr_err != 0) begin
         miscompares++; $display("FAIL rd_addr_seq got %0d bad reads want 0", st_addr_err);
      end
      vectors++;
      if (st_busy_err != 0 || st_idle_err != 0) begin
         miscompares++;
         $display("FAIL empty_busy got %0d/%0d bad cycles want 0", st_busy_err, st_idle_err);
      end
      vectors++;
      if (scr[0][0] !== 3'b100 || scr[8][0] !== 3'b001 || scr[3][3] !== 3'b110) begin
         miscompares++;
         $display("FAIL empty_spots got %b %b %b want 100 001 110",
                  scr[0][0], scr[8][0], scr[3][3]);
      end
   endtask

   task automatic test_stones;
      for (int a = 0; a < 64; a++) mem[a] = 2'b00;
      mem[9] = 2'b01;
      mem[63] = 2'b10;
      run_frame(0, 0, 0);
      vectors++;
      if (scr[9][9] !== 3'b000) begin
         miscompares++; $display("FAIL stone_p0 got %b want 000", scr[9][9]);
      end
      vectors++;
      if (scr[57][57] !== 3'b111) begin
         miscompares++; $display("FAIL stone_p1 got %b want 111", scr[57][57]);
      end
      vectors++;
      if (scr[8][8] !== 3'b001) begin
         miscompares++; $display("FAIL stone_border got %b want 001", scr[8][8]);
      end
      vectors++;
      if (st_pix_err != 0) begin
         miscompares++;
         $display("FAIL stone_pixels got %0d bad, first (%0d,%0d) colour %b want %b",
                  st_pix_err, fb_x, fb_y, fb_c[2:0], fb_ec[2:0]);
      end
   endtask

   task automatic test_cursor_corner;
      for (int a = 0; a < 64; a++) mem[a] = 2'b11;
      run_frame(7, 7, 0);
      for (int t = 56; t < 64; t++) begin
         vectors++;
         if (scr[t][56] !== 3'b100) begin
            miscompares++; $display("FAIL corner_top x=%0d got %b want 100", t, scr[t][56]);
         end
         vectors++;
         if (scr[56][t] !== 3'b100) begin
            miscompares++; $display("FAIL corner_left y=%0d got %b want 100", t, scr[56][t]);
         end
      end
      vectors++;
      if (scr[48][56] !== 3'b001 || scr[60][60] !== 3'b110) begin
         miscompares++;
         $display("FAIL corner_other got %b %b want 001 110", scr[48][56], scr[60][60]);
      end
      vectors++;
      if (st_pix_err != 0) begin
         miscompares++;
         $display("FAIL corner_pixels got %0d bad, first (%0d,%0d) colour %b want %b",
                  st_pix_err, fb_x, fb_y, fb_c[2:0], fb_ec[2:0]);
      end
   endtask

   task automatic test_mid_frame;
      for (int a = 0; a < 64; a++) mem[a] = 2'(a % 3);
      run_frame(2, 5, 1000);
      vectors++;
      if (st_done_k != FRAME + 1 || st_plots != 4096) begin
         miscompares++;
         $display("FAIL mid_restart got done %0d plots %0d want 4225 4096",
                  st_done_k, st_plots);
      end
      vectors++;
      if (st_pix_err != 0) begin
         miscompares++;
         $display("FAIL mid_pixels got %0d bad, first (%0d,%0d) colour %b want %b",
                  st_pix_err, fb_x, fb_y, fb_c[2:0], fb_ec[2:0]);
      end
      vectors++;
      if (scr[40][16] !== 3'b100 || scr[32][24] !== 3'b001) begin
         miscompares++;
         $display("FAIL mid_cursor got %b %b want 100 001", scr[40][16], scr[32][24]);
      end
   endtask

   task automatic test_start_in_done;
      run_frame(1, 1, FRAME + 1);
      vectors++;
      if (st_idle_err != 0 || st_done_cnt != 1) begin
         miscompares++;
         $display("FAIL done_start got %0d busy cycles, %0d dones want 0 1",
                  st_idle_err, st_done_cnt);
      end
   endtask

   task automatic test_reset_mid_draw;
      @(negedge clk);
      bus.cursor_row = '0;
      bus.cursor_col = '0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      vectors++;
      if (bus.plot !== 1'b1 || bus.busy !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_reset got plot %b busy %b want 1 1", bus.plot, bus.busy);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (bus.plot !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got plot %b busy %b done %b want 0 0 0",
                  bus.plot, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (bus.busy !== 1'b0 || bus.plot !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle cycle %0d got busy %b plot %b done %b want 0",
                     k, bus.busy, bus.plot, bus.done);
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset;
      test_empty_board;
      test_stones;
      test_cursor_corner;
      test_mid_frame;
      test_start_in_done;
      test_reset_mid_draw;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
